// File: rtl/mips_mem_pkg.sv
// Shared constants and the state type for the MEM-stage stall controller.
// Defines the default block geometry and the controller's FSM encoding.
package mips_mem_pkg;

  localparam int BLOCK_WORDS_DEF = 4;
  localparam int WORD_OFF_W      = $clog2(BLOCK_WORDS_DEF);
  localparam int BYTE_OFF_W      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } memState_e;

endpackage

// File: rtl/mem_stall_controller_refill_word_counter.sv
// Word index within the cache block being refilled.
// Cleared while idle, advanced once per accepted refill word, flags the final word.
module refill_word_counter
  import mips_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             lastWord
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      // Power-of-two block size: the index wraps to 0 after the last word.
      idx <= idx + IDX_W'(1);
    end
  end

  assign lastWord = (idx == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_stall_controller.sv
// MEM-stage sequencer around the data cache: stalls on read misses (block refill)
// and on write-through stores, and counts read misses with saturation.
module mem_stall_controller
  import mips_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              cache_hit,
  output logic              hit,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  output logic              refill_we,
  output logic [IDX_W-1:0]  refill_idx,
  output logic [CNT_W-1:0]  miss_count
);

  localparam logic [CNT_W-1:0] MISS_MAX = {CNT_W{1'b1}};

  memState_e         state;
  logic [IDX_W-1:0]  idx;
  logic              lastWord;
  logic              reqAccepted;
  logic [ADDR_W-1:0] wordAddr;
  logic [ADDR_W-1:0] blockAddr;

  assign reqAccepted = bus_req && bus_ack;

  refill_word_counter #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .IDX_W      (IDX_W)
  ) u_wordCounter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .inc     ((state == REFILL) && reqAccepted),
    .idx     (idx),
    .lastWord(lastWord)
  );

  // mem_addr is held by the stalled EX/MEM register, so these stay stable during a request.
  assign wordAddr  = mem_addr & ~ADDR_W'(3);
  assign blockAddr = {wordAddr[ADDR_W-1:IDX_W+BYTE_OFF_W], idx, 2'b00};
  assign bus_addr  = bus_we ? wordAddr : blockAddr;

  // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
  always_comb begin
    hit = 1'b0;
    unique case (state)
      IDLE:    hit = !mem_write && (!mem_read || cache_hit);
      DONE:    hit = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      refill_we  <= 1'b0;
      refill_idx <= '0;
      miss_count <= '0;
    end else begin
      refill_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_write) begin
            state   <= WRITE;
            bus_req <= 1'b1;
            bus_we  <= 1'b1;
          end else if (mem_read && !cache_hit) begin
            state   <= REFILL;
            bus_req <= 1'b1;
            bus_we  <= 1'b0;
            if (miss_count != MISS_MAX) begin
              miss_count <= miss_count + CNT_W'(1);
            end
          end
        end
        REFILL: begin
          // bus_req stays high across words so the next word issues without a gap.
          if (reqAccepted) begin
            refill_we  <= 1'b1;
            refill_idx <= idx;
            if (lastWord) begin
              state   <= DONE;
              bus_req <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (reqAccepted) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
